fibonacci_checker: RTL and testbench
====================================

# fibonacci_checker

Stream consumer that verifies a sequence of 16-bit Fibonacci terms produced by the single-rate and double-rate Fibonacci generators, at one or two terms per beat. It sits on the generator's output behind a valid/ready handshake and serves as the in-design self-check for that interface. It tracks the last two accepted terms, predicts the next ones modulo 2^WIDTH, and flags the first mismatch. On a mismatch it halts the stream until restarted.

## Interface
- WIDTH, 16: term width; all arithmetic is modulo 2^WIDTH.
- CNT_W, 16: width of the accepted-term counter.
- CHECK_SEED, 1: when 1, the first two terms must be 1, 1; when 0, any seeds are accepted.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-low. rst = 0 resets the block.
- start  in  1  synchronous restart pulse; takes priority over any beat in the same cycle.
- up_valid  in  1  a beat is offered.
- up_ready  out  1  the block can accept a beat.
- up_pair  in  1  1 = two terms this beat (up_num is term k, up_num2 is term k+1); 0 = up_num only.
- up_num  in  WIDTH  first (or only) term.
- up_num2  in  WIDTH  second term; ignored when up_pair = 0.
- err  out  1  one-cycle pulse on the first mismatch.
- err_exp  out  WIDTH  expected value at the mismatch; held until the next start or reset.
- err_got  out  WIDTH  received value at the mismatch; held.
- failed  out  1  sticky; 1 while in FAIL.
- count  out  CNT_W  number of terms accepted and matched; saturates at all-ones.

## Operation
- Beat accepted when up_valid && up_ready. up_ready = !start && state != FAIL. This is combinational from state and start only, with no dependency on up_valid.
- States are WAIT_A (no terms held), WAIT_B (a held), TRACK (a, b held) and FAIL.
- In WAIT_A and WAIT_B, each seed term is compared against 1 when CHECK_SEED = 1, otherwise it is taken as-is.
- In TRACK, expected e1 = a + b and e2 = b + e1, both truncated to WIDTH.
- Terms within a beat are processed in order: up_num, then up_num2 (when up_pair = 1). A pair may span states:
  - A pair in WAIT_A consumes both seeds and moves to TRACK.
  - A pair in WAIT_B takes up_num as b and checks up_num2 against a + up_num.
- After a matching term t, the history shifts: (a, b) <= (b, t). Expectations always use the received history, which equals the expected values when everything matches.
- On the first mismatching term in a beat:
  - err is pulsed; err_exp and err_got capture that term's values.
  - Go to FAIL. Terms after the mismatch in the same beat are ignored.
  - count adds only the matched terms that preceded the mismatch (0 or 1).
- FAIL: up_ready = 0. Exit only via start or reset.
- start (any state): go to WAIT_A; count, err_exp, err_got and failed clear; err = 0 that cycle. No beat is accepted in the start cycle.
- count adds 1 or 2 per beat, saturating; saturation does not affect checking.

## Timing
- Reset values: state WAIT_A, err = 0, err_exp = 0, err_got = 0, failed = 0, count = 0. up_ready = 1 immediately after reset release while start = 0.
- err, err_exp, err_got, failed and count are registered and update on the edge that accepts the beat. They are visible in the cycle after the handshake.
- up_ready falls in the cycle after the failing beat. It rises in the cycle after start (when start is low again).
- Full throughput: one beat per cycle in any mix of single and pair beats; no bubbles.
- Reset asserted mid-stream clears state asynchronously; an in-flight beat is discarded.

## Test plan
- Single-rate stream 1, 1, 2, 3, 5, 8, 13 → err never pulses, count = 7, failed = 0.
- Pair beats (1,1), (2,3), (5,8), (13,21), back-to-back → count = 8, no error, up_ready held high throughout.
- Wrap-around: run to terms 28657, 46368, then feed 9489 (75025 mod 65536), then 55857 → no error. Separately, feed 75025 truncated incorrectly as 10000 → err with err_exp = 9489, err_got = 10000.
- Mismatch:
  - Single stream 1, 1, 2, 4 → err pulse one cycle after the fourth beat; err_exp = 3, err_got = 4, count = 3, failed = 1, up_ready = 0 while up_valid stays high.
  - Pairs (1,1), (2,3), (5,9) → err_exp = 8, err_got = 9, count = 5.
- Seed and mixed-state pairs:
  - With CHECK_SEED = 1, first term 0 → err_exp = 1, err_got = 0, count = 0.
  - Single 1 followed by pair (1,2) → no error, count = 3.
- Restart and reset:
  - After 1, 1, 2, pulse start together with up_valid → beat not accepted, count = 0. Then 1, 1 → count = 2, no error.
  - Assert rst low mid-stream → all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/fibonacci_checker.sv
// Stream checker for Fibonacci generator output: predicts each incoming term from
// the last two accepted terms (mod 2^WIDTH) and halts on the first mismatch.
module fibonacci_checker #(
  parameter int WIDTH      = 16,
  parameter int CNT_W      = 16,
  parameter bit CHECK_SEED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic             up_pair,
  input  logic [WIDTH-1:0] up_num,
  input  logic [WIDTH-1:0] up_num2,
  output logic             err,
  output logic [WIDTH-1:0] err_exp,
  output logic [WIDTH-1:0] err_got,
  output logic             failed,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    TRACK  = 2'd2,
    FAIL   = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r, state_s, mid_state_s;
  logic [WIDTH-1:0] a_r, b_r, a_s, b_s, mid_a_s, mid_b_s;
  logic             err_r, err_s, failed_r, failed_s;
  logic [WIDTH-1:0] err_exp_r, err_exp_s, err_got_r, err_got_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [WIDTH-1:0] exp1_s, exp2_s;
  logic             accept_s;

  // Seeds are predicted as 1; tracked terms as the sum of the received history.
  function automatic logic [WIDTH-1:0] expect_term(input state_t st, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] e;
    case (st)
      TRACK:   e = a + b;
      default: e = ONE;
    endcase
    return e;
  endfunction

  function automatic logic term_ok(input state_t st, input logic [WIDTH-1:0] t,
                                   input logic [WIDTH-1:0] e);
    return ((st == TRACK) || CHECK_SEED) ? (t == e) : 1'b1;
  endfunction

  function automatic state_t step_state(input state_t st);
    state_t n;
    case (st)
      WAIT_A:  n = WAIT_B;
      WAIT_B:  n = TRACK;
      TRACK:   n = TRACK;
      default: n = FAIL;
    endcase
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  assign up_ready = !start && (state_r != FAIL);
  assign accept_s = up_valid && up_ready;

  // Shift a matched term t into the (a, b) history as seen from state st.
  always_comb begin
    mid_state_s = step_state(state_r);
    exp1_s      = expect_term(state_r, a_r, b_r);
    case (state_r)
      WAIT_A: begin
        mid_a_s = up_num;
        mid_b_s = b_r;
      end
      WAIT_B: begin
        mid_a_s = a_r;
        mid_b_s = up_num;
      end
      TRACK: begin
        mid_a_s = b_r;
        mid_b_s = up_num;
      end
      default: begin
        mid_a_s = a_r;
        mid_b_s = b_r;
      end
    endcase
    exp2_s = expect_term(mid_state_s, mid_a_s, mid_b_s);
  end

  // Next-state, history, and result registers for the beat (start has priority).
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    err_s     = 1'b0;
    err_exp_s = err_exp_r;
    err_got_s = err_got_r;
    failed_s  = failed_r;
    count_s   = count_r;
    if (start) begin
      state_s   = WAIT_A;
      err_exp_s = {WIDTH{1'b0}};
      err_got_s = {WIDTH{1'b0}};
      failed_s  = 1'b0;
      count_s   = {CNT_W{1'b0}};
    end else if (accept_s) begin
      if (!term_ok(state_r, up_num, exp1_s)) begin
        state_s   = FAIL;
        err_s     = 1'b1;
        err_exp_s = exp1_s;
        err_got_s = up_num;
        failed_s  = 1'b1;
      end else if (up_pair) begin
        if (!term_ok(mid_state_s, up_num2, exp2_s)) begin
          state_s   = FAIL;
          err_s     = 1'b1;
          err_exp_s = exp2_s;
          err_got_s = up_num2;
          failed_s  = 1'b1;
          count_s   = sat_add(count_r, 2'd1);
        end else begin
          // Every pair ends with both of its terms as the history.
          state_s = step_state(mid_state_s);
          a_s     = up_num;
          b_s     = up_num2;
          count_s = sat_add(count_r, 2'd2);
        end
      end else begin
        state_s = mid_state_s;
        a_s     = mid_a_s;
        b_s     = mid_b_s;
        count_s = sat_add(count_r, 2'd1);
      end
    end else begin
      state_s = state_r;
    end
  end

  // State, history and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= WAIT_A;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      err_r     <= 1'b0;
      err_exp_r <= {WIDTH{1'b0}};
      err_got_r <= {WIDTH{1'b0}};
      failed_r  <= 1'b0;
      count_r   <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_s;
      a_r       <= a_s;
      b_r       <= b_s;
      err_r     <= err_s;
      err_exp_r <= err_exp_s;
      err_got_r <= err_got_s;
      failed_r  <= failed_s;
      count_r   <= count_s;
    end
  end

  assign err     = err_r;
  assign err_exp = err_exp_r;
  assign err_got = err_got_r;
  assign failed  = failed_r;
  assign count   = count_r;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Directed self-checking bench for fibonacci_checker with hand-computed expectations.
module tb_fibonacci_checker;

  logic        clk;
  logic        rst;
  logic        start;
  logic        up_valid;
  logic        up_ready;
  logic        up_pair;
  logic [15:0] up_num;
  logic [15:0] up_num2;
  logic        err;
  logic [15:0] err_exp;
  logic [15:0] err_got;
  logic        failed;
  logic [15:0] count;

  int n_compared;
  int n_mismatched;
  int err_seen;
  int ready_low_seen;
  logic [15:0] fib_seq [26];

  fibonacci_checker #(.WIDTH(16), .CNT_W(16), .CHECK_SEED(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .up_valid(up_valid), .up_ready(up_ready),
    .up_pair(up_pair), .up_num(up_num), .up_num2(up_num2), .err(err),
    .err_exp(err_exp), .err_got(err_got), .failed(failed), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one beat for one clock; returns #1 after the accepting edge.
  task automatic beat(input logic pair, input logic [15:0] n1, input logic [15:0] n2);
    up_valid = 1'b1;
    up_pair  = pair;
    up_num   = n1;
    up_num2  = n2;
    #1;
    if (!up_ready) ready_low_seen++;
    @(posedge clk);
    #1;
    if (err) err_seen++;
  endtask

  task automatic idle();
    up_valid = 1'b0;
    up_pair  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    up_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start          = 1'b0;
    err_seen       = 0;
    ready_low_seen = 0;
  endtask

  initial begin
    n_compared     = 0;
    n_mismatched   = 0;
    err_seen       = 0;
    ready_low_seen = 0;
    fib_seq = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55,
                16'd89, 16'd144, 16'd233, 16'd377, 16'd610, 16'd987, 16'd1597, 16'd2584,
                16'd4181, 16'd6765, 16'd10946, 16'd17711, 16'd28657, 16'd46368,
                16'd9489, 16'd55857};
    rst      = 1'b0;
    start    = 1'b0;
    up_valid = 1'b0;
    up_pair  = 1'b0;
    up_num   = 16'd0;
    up_num2  = 16'd0;

    #3;
    check_value("rst_err", {31'd0, err}, 32'd0);
    check_value("rst_err_exp", {16'd0, err_exp}, 32'd0);
    check_value("rst_err_got", {16'd0, err_got}, 32'd0);
    check_value("rst_failed", {31'd0, failed}, 32'd0);
    check_value("rst_count", {16'd0, count}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_value("rst_ready", {31'd0, up_ready}, 32'd1);

    // Single-rate stream.
    for (int i = 0; i < 7; i++) beat(1'b0, fib_seq[i], 16'd0);
    idle();
    check_value("single_err", err_seen, 32'd0);
    check_value("single_count", {16'd0, count}, 32'd7);
    check_value("single_failed", {31'd0, failed}, 32'd0);

    // Back-to-back pair beats.
    restart();
    for (int i = 0; i < 8; i += 2) beat(1'b1, fib_seq[i], fib_seq[i+1]);
    idle();
    check_value("pair_err", err_seen, 32'd0);
    check_value("pair_count", {16'd0, count}, 32'd8);
    check_value("pair_ready_low", ready_low_seen, 32'd0);

    // Wrap-around past 2^16.
    restart();
    for (int i = 0; i < 26; i++) beat(1'b0, fib_seq[i], 16'd0);
    idle();
    check_value("wrap_err", err_seen, 32'd0);
    check_value("wrap_count", {16'd0, count}, 32'd26);

    restart();
    for (int i = 0; i < 24; i++) beat(1'b0, fib_seq[i], 16'd0);
    beat(1'b0, 16'd10000, 16'd0);
    check_value("wrap_bad_err", {31'd0, err}, 32'd1);
    check_value("wrap_bad_exp", {16'd0, err_exp}, 32'd9489);
    check_value("wrap_bad_got", {16'd0, err_got}, 32'd10000);
    check_value("wrap_bad_count", {16'd0, count}, 32'd24);

    // Single-stream mismatch with up_valid held high afterwards.
    restart();
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd2, 16'd0);
    beat(1'b0, 16'd4, 16'd0);
    check_value("mis_err", {31'd0, err}, 32'd1);
    check_value("mis_exp", {16'd0, err_exp}, 32'd3);
    check_value("mis_got", {16'd0, err_got}, 32'd4);
    check_value("mis_count", {16'd0, count}, 32'd3);
    check_value("mis_failed", {31'd0, failed}, 32'd1);
    check_value("mis_ready", {31'd0, up_ready}, 32'd0);
    beat(1'b0, 16'd3, 16'd0);
    check_value("mis_err_pulse", {31'd0, err}, 32'd0);
    check_value("mis_hold_count", {16'd0, count}, 32'd3);
    check_value("mis_hold_exp", {16'd0, err_exp}, 32'd3);
    check_value("mis_hold_failed", {31'd0, failed}, 32'd1);

    // Pair mismatch on the second term.
    restart();
    beat(1'b1, 16'd1, 16'd1);
    beat(1'b1, 16'd2, 16'd3);
    beat(1'b1, 16'd5, 16'd9);
    check_value("pmis_err", {31'd0, err}, 32'd1);
    check_value("pmis_exp", {16'd0, err_exp}, 32'd8);
    check_value("pmis_got", {16'd0, err_got}, 32'd9);
    check_value("pmis_count", {16'd0, count}, 32'd5);

    // Bad seed.
    restart();
    check_value("start_clr_failed", {31'd0, failed}, 32'd0);
    beat(1'b0, 16'd0, 16'd0);
    check_value("seed_err", {31'd0, err}, 32'd1);
    check_value("seed_exp", {16'd0, err_exp}, 32'd1);
    check_value("seed_got", {16'd0, err_got}, 32'd0);
    check_value("seed_count", {16'd0, count}, 32'd0);

    // Pair spanning WAIT_B into TRACK.
    restart();
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b1, 16'd1, 16'd2);
    idle();
    check_value("span_err", err_seen, 32'd0);
    check_value("span_count", {16'd0, count}, 32'd3);
    check_value("span_failed", {31'd0, failed}, 32'd0);
    restart();
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b1, 16'd1, 16'd3);
    check_value("span_bad_exp", {16'd0, err_exp}, 32'd2);
    check_value("span_bad_count", {16'd0, count}, 32'd2);

    // Start beats a concurrent valid beat.
    restart();
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd2, 16'd0);
    start    = 1'b1;
    up_valid = 1'b1;
    up_pair  = 1'b0;
    up_num   = 16'd3;
    #1;
    check_value("start_ready", {31'd0, up_ready}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check_value("start_count", {16'd0, count}, 32'd0);
    err_seen = 0;
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd1, 16'd0);
    idle();
    check_value("restart_count", {16'd0, count}, 32'd2);
    check_value("restart_err", err_seen, 32'd0);

    // Asynchronous reset mid-stream, right after a failing beat.
    restart();
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd2, 16'd0);
    beat(1'b0, 16'd4, 16'd0);
    rst = 1'b0;
    #1;
    check_value("arst_err", {31'd0, err}, 32'd0);
    check_value("arst_exp", {16'd0, err_exp}, 32'd0);
    check_value("arst_got", {16'd0, err_got}, 32'd0);
    check_value("arst_failed", {31'd0, failed}, 32'd0);
    check_value("arst_count", {16'd0, count}, 32'd0);
    up_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_value("arst_ready", {31'd0, up_ready}, 32'd1);
    err_seen = 0;
    beat(1'b0, 16'd1, 16'd0);
    beat(1'b0, 16'd1, 16'd0);
    idle();
    check_value("arst_resume_count", {16'd0, count}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
